// File: rtl/conv_feeder.sv
// Raster pixel stream to 3-row column feeder for the 3x3 convolver, with result coordinate tagging.
// Define CONV_FEEDER_KLOAD_EN to include the 9-coefficient kernel load phase.
module conv_feeder #(
  parameter int BIT_LEN = 8,
  parameter int IMG_W   = 64,
  parameter int IMG_H   = 64,
  parameter int AW      = $clog2(IMG_W),
  parameter int RW      = $clog2(IMG_H)
) (
  input  logic               CLK100MHZ,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [BIT_LEN-1:0] i_data,
  input  logic               i_data_valid,
  output logic               o_data_ready,
  output logic [BIT_LEN-1:0] o_dato0,
  output logic [BIT_LEN-1:0] o_dato1,
  output logic [BIT_LEN-1:0] o_dato2,
  output logic               o_selecK_I,
  output logic               o_valid,
  output logic               o_res_valid,
  output logic [RW-1:0]      o_res_row,
  output logic [AW-1:0]      o_res_col,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {S_IDLE, S_KLOAD, S_IMG, S_FLUSH} state_t;

  state_t r_state, w_nextState;

  logic [RW-1:0]      r_row;
  logic [AW-1:0]      r_col;
  logic [AW:0]        r_pushK;
  logic [BIT_LEN-1:0] r_dato0, r_dato1, r_dato2;
  logic               r_valid;
  logic               r_resPend;
  logic [RW-1:0]      r_pendRow;
  logic [AW-1:0]      r_pendCol;
  logic               r_res_valid;
  logic [RW-1:0]      r_res_row;
  logic [AW-1:0]      r_res_col;
  logic               r_done;
  logic [BIT_LEN-1:0] r_lb0 [IMG_W];
  logic [BIT_LEN-1:0] r_lb1 [IMG_W];

`ifdef CONV_FEEDER_KLOAD_EN
  logic [3:0]         r_kcnt;
  logic [1:0]         r_kpos;
  logic [BIT_LEN-1:0] r_k0, r_k1;
  logic               r_selecK_I;
  assign o_selecK_I = r_selecK_I;
`else
  assign o_selecK_I = 1'b1;
`endif

  logic          w_accept;
  logic          w_lastCol;
  logic          w_rowLast;
  logic          w_rowGe2;
  logic [AW:0]   w_kMinus3;
  logic [RW-1:0] w_resRow;

  assign o_data_ready = (r_state == S_IMG) || (r_state == S_KLOAD);
  assign w_accept     = i_data_valid && o_data_ready;
  assign w_lastCol    = (r_col == AW'(IMG_W - 1));
  assign w_rowLast    = (r_row == RW'(IMG_H - 1));
  assign w_rowGe2     = (r_row >= RW'(2));
  assign w_kMinus3    = r_pushK - (AW+1)'(3);
  assign w_resRow     = r_row - RW'(2);

  assign o_dato0     = r_dato0;
  assign o_dato1     = r_dato1;
  assign o_dato2     = r_dato2;
  assign o_valid     = r_valid;
  assign o_res_valid = r_res_valid;
  assign o_res_row   = r_res_row;
  assign o_res_col   = r_res_col;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: if (i_start) begin
`ifdef CONV_FEEDER_KLOAD_EN
        w_nextState = S_KLOAD;
`else
        w_nextState = S_IMG;
`endif
      end
`ifdef CONV_FEEDER_KLOAD_EN
      S_KLOAD: if (w_accept && r_kcnt == 4'd8) w_nextState = S_IMG;
`endif
      S_IMG:   if (w_accept && w_lastCol && w_rowGe2) w_nextState = S_FLUSH;
      S_FLUSH: w_nextState = w_rowLast ? S_IDLE : S_IMG;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Line buffers shift one row per accepted pixel; old contents are read by the push path first.
  always_ff @(posedge CLK100MHZ) begin
    if (!i_reset && r_state == S_IMG && w_accept) begin
      r_lb0[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= i_data;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (i_reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_pushK     <= '0;
      r_dato0     <= '0;
      r_dato1     <= '0;
      r_dato2     <= '0;
      r_valid     <= 1'b0;
      r_resPend   <= 1'b0;
      r_pendRow   <= '0;
      r_pendCol   <= '0;
      r_res_valid <= 1'b0;
      r_res_row   <= '0;
      r_res_col   <= '0;
      r_done      <= 1'b0;
`ifdef CONV_FEEDER_KLOAD_EN
      r_kcnt      <= '0;
      r_kpos      <= '0;
      r_k0        <= '0;
      r_k1        <= '0;
      r_selecK_I  <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_resPend   <= 1'b0;
      r_done      <= 1'b0;
      r_res_valid <= r_resPend;
      r_res_row   <= r_pendRow;
      r_res_col   <= r_pendCol;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_row   <= '0;
          r_col   <= '0;
          r_pushK <= '0;
`ifdef CONV_FEEDER_KLOAD_EN
          r_kcnt  <= '0;
          r_kpos  <= '0;
`endif
        end
`ifdef CONV_FEEDER_KLOAD_EN
        S_KLOAD: if (w_accept) begin
          r_kcnt <= r_kcnt + 4'd1;
          case (r_kpos)
            2'd0: begin r_k0 <= i_data; r_kpos <= 2'd1; end
            2'd1: begin r_k1 <= i_data; r_kpos <= 2'd2; end
            default: begin
              r_dato0    <= r_k0;
              r_dato1    <= r_k1;
              r_dato2    <= i_data;
              r_selecK_I <= 1'b0;
              r_valid    <= 1'b1;
              r_kpos     <= 2'd0;
            end
          endcase
        end
`endif
        S_IMG: if (w_accept) begin
          if (w_rowGe2) begin
            r_dato0 <= r_lb0[r_col];
            r_dato1 <= r_lb1[r_col];
            r_dato2 <= i_data;
`ifdef CONV_FEEDER_KLOAD_EN
            r_selecK_I <= 1'b1;
`endif
            r_valid <= 1'b1;
            r_pushK <= r_pushK + (AW+1)'(1);
            if (r_pushK >= (AW+1)'(3)) begin
              r_resPend <= 1'b1;
              r_pendRow <= w_resRow;
              r_pendCol <= w_kMinus3[AW-1:0];
            end
          end
          // Output rows advance the row counter in FLUSH so the flush push still sees row r.
          if (w_lastCol) begin
            r_col <= '0;
            if (!w_rowGe2) r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + AW'(1);
          end
        end
        S_FLUSH: begin
          r_dato0 <= '0;
          r_dato1 <= '0;
          r_dato2 <= '0;
`ifdef CONV_FEEDER_KLOAD_EN
          r_selecK_I <= 1'b1;
`endif
          r_valid <= 1'b1;
          r_pushK <= '0;
          if (r_pushK >= (AW+1)'(3)) begin
            r_resPend <= 1'b1;
            r_pendRow <= w_resRow;
            r_pendCol <= w_kMinus3[AW-1:0];
          end
          if (w_rowLast) r_done <= 1'b1;
          else           r_row  <= r_row + RW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
